exec_unit: RTL and testbench
============================

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 SHALL use one clock and one reset: clk, rising edge; rst_n, asynchronous, active-low.
REQ-002 SHALL have ports:
  clk  in  1  clock
  rst_n  in  1  async active-low reset
  instr_valid  in  1  decoded op offered
  instr_ready  out  1  unit can accept op
  opcode  in  4  operation code
  rd  in  3  destination register
  rs1  in  3  source register 1
  rs2  in  3  source register 2
  imm  in  8  immediate
  readAddr1  out  3  register-file read port 1 address
  readAddr2  out  3  register-file read port 2 address
  readData1  in  16  register-file read data 1, valid one clk after address
  readData2  in  16  register-file read data 2, valid one clk after address
  writeAddr  out  3  register-file write address
  writeEnable  out  1  register-file write strobe
  writeData  out  16  register-file write data
  busy  out  1  op in flight
  flag_z  out  1  zero flag
  flag_c  out  1  carry/borrow flag
  illegal  out  1  one-cycle pulse on undefined opcode

Function
REQ-003 SHALL use FSM states IDLE, READ, EXEC, MUL, WB.
REQ-004 Accept SHALL occur on an edge where instr_valid=1 in IDLE; instr_ready=1 only in IDLE; busy=!instr_ready.
REQ-005 On accept, SHALL register opcode/rd/imm, drive readAddr1=rs1 and readAddr2=rs2 (held until the next accept), and go to READ.
REQ-006 READ SHALL last exactly one cycle, then go to EXEC; operands SHALL be sampled from readData1/readData2 only in EXEC.
REQ-007 Opcodes SHALL be: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SHL by readData2[3:0], 7 SHR (logical) by readData2[3:0], 8 LI = {8'h00, imm}, 9 MUL (low 16 bits of product), 10-15 undefined.
REQ-008 ADD/SUB SHALL use a 17-bit result; flag_c = bit16 (carry for ADD, borrow for SUB); the result SHALL wrap modulo 2^16.
REQ-009 EXEC SHALL register the result and go to WB, except: MUL goes to MUL; NOP and undefined opcodes go to IDLE with no write.
REQ-010 An undefined opcode SHALL pulse illegal for the EXEC cycle only.
REQ-011 MUL SHALL be iterative shift-add, 1 bit per cycle, 16 cycles counted by a 4-bit counter, then go to WB; accept-to-writeEnable latency is 19 cycles.
REQ-012 WB SHALL last one cycle, with writeEnable=1, writeAddr=rd and writeData=result, then go to IDLE; accept-to-writeEnable latency is 3 cycles for non-MUL ops.
REQ-013 writeEnable SHALL be 1 only in WB.
REQ-014 flag_z SHALL update in WB to (writeData==0); flag_c SHALL update in WB only for ADD/SUB; both flags hold otherwise.
REQ-015 Back-to-back ops SHALL see earlier writes without forwarding: the next accept is no earlier than the WB exit edge, so its read follows the write.
REQ-016 instr_valid while busy SHALL be ignored; opcode/rd/rs1/rs2/imm changes outside the accept edge SHALL have no effect.
REQ-017 rd=rs1=rs2 SHALL be legal; rd=0 SHALL be written like any other register (no hardwired zero).

Reset
REQ-018 rst_n low SHALL immediately force state IDLE, readAddr1=readAddr2=writeAddr=0, writeEnable=0, writeData=0, flag_z=0, flag_c=0, illegal=0, MUL counter=0.
REQ-019 Reset mid-operation SHALL abort the op with no write; the first accept SHALL be possible on the first clk edge after rst_n rises.

Structure
REQ-020 A shared package SHALL hold the opcode constants, the FSM state encoding, and the data/address widths (16 and 3).
REQ-021 The datapath SHALL be one sub-module, exec_alu (combinational: opcode, a, b, imm -> 17-bit result); the MUL iteration SHALL stay in exec_unit.

Verification
REQ-022 Bench SHALL model the register file as a registered 1-cycle-read, 8x16 array, with R1=0x7FFF and R2=0x0001 preloaded.
REQ-023 ADD rd=3, rs1=1, rs2=2 -> writeEnable 3 cycles after accept, writeAddr=3, writeData=0x8000, flag_z=0, flag_c=0.
REQ-024 SUB rd=4, rs1=2, rs2=1 -> writeData=0x8002, flag_c=1; then SUB rd=5, rs1=1, rs2=1 -> writeData=0, flag_z=1.
REQ-025 MUL rd=6, rs1=1, rs2=1 with R1=0x0003 -> writeEnable 19 cycles after accept, writeData=0x0009; instr_ready=0 throughout.
REQ-026 Back-to-back LI rd=1, imm=0xAB then ADD rd=2, rs1=1, rs2=1 -> second op writes 0x0156.
REQ-027 Opcode 0xF -> illegal pulse 2 cycles after accept, no writeEnable; rst_n dropped in MUL cycle 5 -> all outputs at reset values, no write.

Source files
------------

// File: rtl/exec_unit_pkg.sv
// Shared definitions for the execution unit: widths, opcodes, FSM encoding.
package exec_unit_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int OP_W   = 4;

    // Opcode map; 10..15 are undefined.
    localparam logic [OP_W-1:0] OP_NOP = 4'd0;
    localparam logic [OP_W-1:0] OP_ADD = 4'd1;
    localparam logic [OP_W-1:0] OP_SUB = 4'd2;
    localparam logic [OP_W-1:0] OP_AND = 4'd3;
    localparam logic [OP_W-1:0] OP_OR  = 4'd4;
    localparam logic [OP_W-1:0] OP_XOR = 4'd5;
    localparam logic [OP_W-1:0] OP_SHL = 4'd6;
    localparam logic [OP_W-1:0] OP_SHR = 4'd7;
    localparam logic [OP_W-1:0] OP_LI  = 4'd8;
    localparam logic [OP_W-1:0] OP_MUL = 4'd9;

    // FSM state encoding.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_READ = 3'd1;
    localparam logic [2:0] ST_EXEC = 3'd2;
    localparam logic [2:0] ST_MUL  = 3'd3;
    localparam logic [2:0] ST_WB   = 3'd4;

    // True for opcodes the unit knows how to execute.
    function automatic logic op_defined(input logic [OP_W-1:0] op);
        return (op <= OP_MUL);
    endfunction

    // Only ADD and SUB produce a meaningful carry/borrow.
    function automatic logic op_sets_carry(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/exec_alu.sv
// Single-cycle combinational datapath; bit 16 carries ADD carry / SUB borrow.
module exec_alu
    import exec_unit_pkg::*;
(
    input  logic [OP_W-1:0]   opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [7:0]        imm,
    output logic [DATA_W:0]   result
);

    // Result select; MUL is iterated in the parent, so it yields zero here.
    always_comb begin
        result = '0;
        case (opcode)
            OP_ADD:  result = {1'b0, a} + {1'b0, b};
            OP_SUB:  result = {1'b0, a} - {1'b0, b};
            OP_AND:  result = {1'b0, a & b};
            OP_OR:   result = {1'b0, a | b};
            OP_XOR:  result = {1'b0, a ^ b};
            OP_SHL:  result = {1'b0, a << b[3:0]};
            OP_SHR:  result = {1'b0, a >> b[3:0]};
            OP_LI:   result = {9'h000, imm};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/exec_unit.sv
// Multi-cycle execution unit: reads two registers, runs one ALU op (or a
// 16-step shift-add multiply) and writes the result back.
//
// Handshake: an op transfers on a rising clk edge where instr_valid and
// instr_ready are both 1. instr_ready is 1 only in IDLE; instr_valid while
// busy is ignored, and opcode/rd/rs1/rs2/imm matter only on the transfer edge.
module exec_unit
    import exec_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [OP_W-1:0]   opcode,
    input  logic [ADDR_W-1:0] rd,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [7:0]        imm,
    output logic [ADDR_W-1:0] readAddr1,
    output logic [ADDR_W-1:0] readAddr2,
    input  logic [DATA_W-1:0] readData1,
    input  logic [DATA_W-1:0] readData2,
    output logic [ADDR_W-1:0] writeAddr,
    output logic              writeEnable,
    output logic [DATA_W-1:0] writeData,
    output logic              busy,
    output logic              flag_z,
    output logic              flag_c,
    output logic              illegal
);

    logic [2:0]        state;
    logic [2:0]        state_next;
    logic [OP_W-1:0]   op_q;
    logic [ADDR_W-1:0] rd_q;
    logic [7:0]        imm_q;
    logic [DATA_W:0]   result_q;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [3:0]        mul_cnt;
    logic [DATA_W:0]   alu_result;
    logic              accept;

    assign accept      = (state == ST_IDLE) && instr_valid;
    assign instr_ready = (state == ST_IDLE);
    assign busy        = !instr_ready;
    assign writeEnable = (state == ST_WB);
    assign writeAddr   = rd_q;
    assign writeData   = result_q[DATA_W-1:0];
    assign illegal     = (state == ST_EXEC) && !op_defined(op_q);

    // Operands come straight from the register file during EXEC.
    exec_alu u_alu (
        .opcode (op_q),
        .a      (readData1),
        .b      (readData2),
        .imm    (imm_q),
        .result (alu_result)
    );

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (instr_valid) state_next = ST_READ;
            ST_READ: state_next = ST_EXEC;
            ST_EXEC: begin
                if (op_q == OP_MUL)
                    state_next = ST_MUL;
                else if (op_q == OP_NOP || !op_defined(op_q))
                    state_next = ST_IDLE;
                else
                    state_next = ST_WB;
            end
            ST_MUL:  if (mul_cnt == 4'd15) state_next = ST_WB;
            ST_WB:   state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Op capture, operand addressing, ALU result and multiply iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_NOP;
            rd_q      <= '0;
            imm_q     <= '0;
            readAddr1 <= '0;
            readAddr2 <= '0;
            result_q  <= '0;
            mcand     <= '0;
            mplier    <= '0;
            mul_cnt   <= '0;
        end else begin
            if (accept) begin
                op_q      <= opcode;
                rd_q      <= rd;
                imm_q     <= imm;
                readAddr1 <= rs1;
                readAddr2 <= rs2;
            end
            if (state == ST_EXEC) begin
                if (op_q == OP_MUL) begin
                    mcand    <= readData1;
                    mplier   <= readData2;
                    result_q <= '0;
                    mul_cnt  <= '0;
                end else if (state_next == ST_WB) begin
                    result_q <= alu_result;
                end
            end
            if (state == ST_MUL) begin
                // One multiplier bit per cycle; only the low 16 bits are kept.
                result_q <= {1'b0, result_q[DATA_W-1:0] + (mplier[0] ? mcand : '0)};
                mcand    <= mcand << 1;
                mplier   <= mplier >> 1;
                mul_cnt  <= mul_cnt + 4'd1;
            end
        end
    end

    // Flags latch on the write-back cycle; carry only for ADD/SUB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else if (state == ST_WB) begin
            flag_z <= (result_q[DATA_W-1:0] == '0);
            if (op_sets_carry(op_q)) flag_c <= result_q[DATA_W];
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit with a registered 8x16 register-file model.
module tb_exec_unit;
    import exec_unit_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  opcode;
    logic [2:0]  rd, rs1, rs2;
    logic [7:0]  imm;
    logic [2:0]  readAddr1, readAddr2;
    logic [15:0] readData1, readData2;
    logic [2:0]  writeAddr;
    logic        writeEnable;
    logic [15:0] writeData;
    logic        busy, flag_z, flag_c, illegal;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    logic        rf_load;
    logic [15:0] rf[8];

    exec_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .imm         (imm),
        .readAddr1   (readAddr1),
        .readAddr2   (readAddr2),
        .readData1   (readData1),
        .readData2   (readData2),
        .writeAddr   (writeAddr),
        .writeEnable (writeEnable),
        .writeData   (writeData),
        .busy        (busy),
        .flag_z      (flag_z),
        .flag_c      (flag_c),
        .illegal     (illegal)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: synchronous write, registered read (data one clk after address).
    always @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < 8; i++) rf[i] <= 16'h0000;
            rf[1] <= 16'h7FFF;
            rf[2] <= 16'h0001;
        end else if (writeEnable) begin
            rf[writeAddr] <= writeData;
        end
        readData1 <= rf[readAddr1];
        readData2 <= rf[readAddr2];
    end

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [2:0]  rd, rs1, rs2;
        logic [7:0]  imm;
        int          lat;    // cycles from accept cycle to writeEnable; 0 = no write
        logic [15:0] data;
        logic        z, c, ill;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic [3:0] op, logic [2:0] d, logic [2:0] s1,
                                logic [2:0] s2, logic [7:0] im, int lat, logic [15:0] data,
                                logic z, logic c, logic ill);
        vec_t v;
        v.name = name; v.op = op; v.rd = d; v.rs1 = s1; v.rs2 = s2; v.imm = im;
        v.lat = lat; v.data = data; v.z = z; v.c = c; v.ill = ill;
        return v;
    endfunction

    // Scoreboard compare
    task automatic chk(input string name, input logic [16:0] act, input logic [16:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ".readAddr1"},   17'(readAddr1),   17'h0);
        chk({tag, ".readAddr2"},   17'(readAddr2),   17'h0);
        chk({tag, ".writeAddr"},   17'(writeAddr),   17'h0);
        chk({tag, ".writeEnable"}, 17'(writeEnable), 17'h0);
        chk({tag, ".writeData"},   17'(writeData),   17'h0);
        chk({tag, ".flag_z"},      17'(flag_z),      17'h0);
        chk({tag, ".flag_c"},      17'(flag_c),      17'h0);
        chk({tag, ".illegal"},     17'(illegal),     17'h0);
        chk({tag, ".instr_ready"}, 17'(instr_ready), 17'h1);
        chk({tag, ".busy"},        17'(busy),        17'h0);
    endtask

    task automatic drive_garbage();
        instr_valid = 1'b1;
        opcode = 4'($urandom_range(0, 15));
        rd     = 3'($urandom_range(0, 7));
        rs1    = 3'($urandom_range(0, 7));
        rs2    = 3'($urandom_range(0, 7));
        imm    = 8'($urandom_range(0, 255));
    endtask

    // Driver: called at a negedge with the DUT idle; returns at the negedge of
    // the first idle cycle after the op, so consecutive calls are back-to-back.
    task automatic run_vec(input vec_t v);
        int idle_c, stray, rdy_bad, ill_bad;
        logic [15:0] exp_d;
        idle_c = (v.lat == 0) ? 3 : v.lat + 1;
        stray = 0; rdy_bad = 0; ill_bad = 0;
        if (v.lat != 0) exp_q.push_back(v.data);
        opcode = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm;
        instr_valid = 1'b1;
        if (instr_ready !== 1'b1) rdy_bad++;
        @(posedge clk);
        #1 drive_garbage();
        for (int n = 1; n <= idle_c; n++) begin
            @(negedge clk);
            if (n == v.lat) begin
                chk({v.name, ".writeEnable"}, 17'(writeEnable), 17'h1);
                chk({v.name, ".writeAddr"},   17'(writeAddr),   17'(v.rd));
                exp_d = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
                chk({v.name, ".writeData"},   17'(writeData),   17'(exp_d));
            end else if (writeEnable !== 1'b0) begin
                stray++;
            end
            if (instr_ready !== (n >= idle_c) || busy !== (n < idle_c)) rdy_bad++;
            if (illegal !== (v.ill && n == 2)) ill_bad++;
            if (n < idle_c) drive_garbage();
            else instr_valid = 1'b0;
        end
        chk({v.name, ".stray_we"}, 17'(stray),   17'h0);
        chk({v.name, ".ready"},    17'(rdy_bad), 17'h0);
        chk({v.name, ".illegal"},  17'(ill_bad), 17'h0);
        chk({v.name, ".flag_z"},   17'(flag_z),  17'(v.z));
        chk({v.name, ".flag_c"},   17'(flag_c),  17'(v.c));
    endtask

    initial begin
        int stray;
        // Expected values hand-computed from the running register contents.
        vecs.push_back(mk("add_r1_r2",  OP_ADD, 3, 1, 2, 8'h00,  3, 16'h8000, 0, 0, 0));
        vecs.push_back(mk("sub_borrow", OP_SUB, 4, 2, 1, 8'h00,  3, 16'h8002, 0, 1, 0));
        vecs.push_back(mk("and_zero",   OP_AND, 6, 1, 3, 8'h00,  3, 16'h0000, 1, 1, 0));
        vecs.push_back(mk("sub_zero",   OP_SUB, 5, 1, 1, 8'h00,  3, 16'h0000, 1, 0, 0));
        vecs.push_back(mk("or",         OP_OR,  7, 3, 2, 8'h00,  3, 16'h8001, 0, 0, 0));
        vecs.push_back(mk("xor_rd0",    OP_XOR, 0, 1, 4, 8'h00,  3, 16'hFFFD, 0, 0, 0));
        vecs.push_back(mk("shl",        OP_SHL, 5, 2, 4, 8'h00,  3, 16'h0004, 0, 0, 0));
        vecs.push_back(mk("shr",        OP_SHR, 6, 3, 5, 8'h00,  3, 16'h0800, 0, 0, 0));
        vecs.push_back(mk("add_wrap",   OP_ADD, 7, 3, 3, 8'h00,  3, 16'h0000, 1, 1, 0));
        vecs.push_back(mk("li_ab",      OP_LI,  1, 0, 0, 8'hAB,  3, 16'h00AB, 0, 1, 0));
        vecs.push_back(mk("add_b2b",    OP_ADD, 2, 1, 1, 8'h00,  3, 16'h0156, 0, 0, 0));
        vecs.push_back(mk("nop",        OP_NOP, 3, 1, 1, 8'h00,  0, 16'h0000, 0, 0, 0));
        vecs.push_back(mk("undef_f",    4'hF,   3, 1, 1, 8'h00,  0, 16'h0000, 0, 0, 1));
        vecs.push_back(mk("li_3",       OP_LI,  1, 0, 0, 8'h03,  3, 16'h0003, 0, 0, 0));
        vecs.push_back(mk("mul_3x3",    OP_MUL, 6, 1, 1, 8'h00, 19, 16'h0009, 0, 0, 0));
        vecs.push_back(mk("mul_wrap",   OP_MUL, 7, 2, 0, 8'h00, 19, 16'hFBFE, 0, 0, 0));
        vecs.push_back(mk("sub_r5_r7",  OP_SUB, 0, 5, 7, 8'h00,  3, 16'h0406, 0, 1, 0));
        vecs.push_back(mk("undef_a",    4'hA,   1, 2, 3, 8'h00,  0, 16'h0000, 0, 1, 1));
        vecs.push_back(mk("shl_14",     OP_SHL, 3, 1, 7, 8'h00,  3, 16'hC000, 0, 1, 0));

        rst_n = 1'b0; rf_load = 1'b1; instr_valid = 1'b0;
        opcode = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_values("reset");
        rf_load = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset during MUL cycle 5: op aborted, outputs at reset values, no write.
        opcode = OP_MUL; rd = 3'd4; rs1 = 3'd1; rs2 = 3'd1; imm = 8'h00;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        stray = 0;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            if (writeEnable !== 1'b0) stray++;
        end
        chk("mid_mul.busy", 17'(busy), 17'h1);
        rst_n = 1'b0;
        #1 chk_reset_values("mid_mul_reset");
        repeat (3) begin
            @(negedge clk);
            if (writeEnable !== 1'b0) stray++;
        end
        chk("mid_mul.stray_we", 17'(stray), 17'h0);
        chk("mid_mul.r4_kept", 17'(rf[4]), 17'h8002);
        rst_n = 1'b1;
        // First edge after reset release must accept.
        run_vec(mk("li_after_reset", OP_LI, 2, 0, 0, 8'h55, 3, 16'h0055, 0, 0, 0));

        chk("exp_q_empty", 17'(exp_q.size()), 17'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
